// File: rtl/pipeline_elastic_pkg.sv
// Shared definitions for the elastic ready/valid pipeline: default sizes,
// a constant-evaluable clog2 and the occupancy counter width.
package pipeline_elastic_pkg;

  localparam int DW_DEF = 64;
  localparam int N_DEF  = 16;

  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Counter width for the default depth: stages plus the optional skid entry.
  localparam int CNT_W = clog2(N_DEF + 2);

endpackage

// File: rtl/pipeline_elastic_if.sv
// Ready/valid/data handshake bundle used on both sides of pipeline_elastic.
// master drives valid/data and receives ready; slave is the mirror image.
interface pipeline_elastic_if
  import pipeline_elastic_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_skid.sv
// One-entry skid buffer: in_ready depends only on registered state, so the
// upstream ready path is cut from the downstream ready.
module pipeline_skid #(
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  assign in_ready  = ~skid_valid_q & ~reset;
  assign out_valid = skid_valid_q | in_valid;
  assign out_data  = skid_valid_q ? skid_data_q : in_data;

  // NOTE: defaults are assigned first so every path drives every output and no latch is inferred.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (out_ready) skid_valid_d = 1'b0;
    end else if (in_valid && in_ready && !out_ready) begin
      // Word accepted while the stage behind us is stalled: park it.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // NOTE: non-blocking assignments let every flop sample the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) skid_valid_q <= 1'b0;
    else       skid_valid_q <= skid_valid_d;
  end

  // NOTE: payload flops carry no reset; they are only observed while the matching valid bit is set.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

endmodule

// File: rtl/pipeline_elastic.sv
// pipeline_elastic: N-stage ready/valid pipeline with bubble collapse and an
// occupancy count. Define PIPELINE_ELASTIC_SKID_EN to add a registered-ready skid entry.
module pipeline_elastic
  import pipeline_elastic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int N  = N_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_elastic_if.slave     up,
  pipeline_elastic_if.master    dn,
  output logic [clog2(N+2)-1:0] count
);

  localparam int CW = clog2(N + 2);

  logic [N-1:0]         v_q, v_d, rdy, src_v;
  logic [N-1:0][DW-1:0] d_q, d_d, src_d;
  logic                 s_valid;
  logic [DW-1:0]        s_data;
  logic                 in_xfer, out_xfer;
  logic [CW-1:0]        count_q, count_d;

`ifdef PIPELINE_ELASTIC_SKID_EN
  pipeline_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (up.valid),
    .in_ready  (up.ready),
    .in_data   (up.data),
    .out_valid (s_valid),
    .out_ready (rdy[0]),
    .out_data  (s_data)
  );
`else
  assign s_valid  = up.valid;
  assign s_data   = up.data;
  assign up.ready = rdy[0] & ~reset;
`endif

  // A stage can load when it or any stage downstream of it has a free slot.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign rdy[i] = dn.ready | ~(&v_q[N-1:i]);
  end

  assign src_v[0] = s_valid;
  assign src_d[0] = s_data;
  for (genvar i = 1; i < N; i++) begin : g_src
    assign src_v[i] = v_q[i-1];
    assign src_d[i] = d_q[i-1];
  end

  // Data only toggles when a real word arrives, keeping bubbles quiet.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        v_d[i] = src_v[i];
        if (src_v[i]) d_d[i] = src_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) v_q <= '0;
    else       v_q <= v_d;
  end

  always_ff @(posedge clk) begin
    d_q <= d_d;
  end

  assign in_xfer  = up.valid & up.ready;
  assign out_xfer = dn.valid & dn.ready;

  always_comb begin
    count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count    = count_q;
  assign dn.valid = v_q[N-1];
  assign dn.data  = d_q[N-1];

`ifndef SYNTHESIS
  a_in_stable: assert property (@(posedge clk) disable iff (reset)
    (up.valid && !up.ready) |=> (up.valid && $stable(up.data)));

  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    (dn.valid && !dn.ready) |=> (dn.valid && $stable(dn.data)));
`endif

endmodule
